// File: rtl/apb_write_master_if.sv
// APB write bus between the write requester (master) and a completer (slave).
interface apb_write_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;

  modport master (
    output PSEL,
    output PENABLE,
    output PWRITE,
    output PADDR,
    output PWDATA,
    input  PREADY
  );

  modport slave (
    input  PSEL,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    input  PWDATA,
    output PREADY
  );
endinterface

// File: rtl/apb_write_master.sv
// Drains a small (address, data) command FIFO as APB write transfers with
// wait-state tolerance, per-transfer timeout and done/timeout pulses.
module apb_write_master #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  apb_write_master_if.master  apb,
  output logic                done,
  output logic                timeout_err,
  output logic                busy
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TCNT_W:0]   TO_LIMIT = (TCNT_W + 1)'(TIMEOUT);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  cmd_t              mem [FIFO_DEPTH];
  cmd_t              head;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [TCNT_W-1:0] tcnt_q;
  logic [TCNT_W-1:0] tcnt_d;
  logic [TCNT_W:0]   tcnt_inc;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              done_d;
  logic              terr_d;
  logic              psel_q;
  logic              penable_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;

  assign push       = cmd_valid && cmd_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem[rd_ptr_q];

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = psel_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;

  // Storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem[wr_ptr_q] <= {cmd_addr, cmd_data};
    end
  end

  // Next state, pop decision and timeout tracking.
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    pop      = 1'b0;
    done_d   = 1'b0;
    terr_d   = 1'b0;
    tcnt_inc = {1'b0, tcnt_q} + (TCNT_W + 1)'(1);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        tcnt_d  = '0;
      end
      ACCESS: begin
        // A PREADY arriving on the last allowed cycle still completes.
        if (apb.PREADY) begin
          done_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else if (tcnt_inc >= TO_LIMIT) begin
          terr_d  = 1'b1;
          state_d = IDLE;
          tcnt_d  = TO_LIMIT[TCNT_W-1:0];
        end else begin
          tcnt_d = tcnt_inc[TCNT_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State, FIFO bookkeeping and registered outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tcnt_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      tcnt_q      <= tcnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        paddr_q  <= head.addr & ALIGN_MASK;
        pwdata_q <= head.data;
      end
      psel_q      <= (state_d != IDLE);
      penable_q   <= (state_d == ACCESS);
      done        <= done_d;
      timeout_err <= terr_d;
      busy        <= (count_d != '0) || (state_d != IDLE);
      cmd_ready   <= (count_d != FULL_CNT);
    end
  end

endmodule

// File: tb/tb_apb_write_master.sv
// Directed bench for apb_write_master: scoreboard of expected bus writes plus
// a small wait-count model for done/timeout pulse timing.
module tb_apb_write_master;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 16;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic              PCLK;
  logic              PRESET;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              done;
  logic              timeout_err;
  logic              busy;

  apb_write_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

  apb_write_master #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .apb        (apb),
    .done       (done),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_psel, n_pen, n_done, n_terr, n_fall, wcnt;
  logic exp_done, exp_terr, exp_psel_low, prev_psel, last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_psel = 0; n_pen = 0; n_done = 0; n_terr = 0; n_fall = 0;
  endtask

  // Sample on the falling edge, update model/scoreboard, return 1ns after the rising edge.
  task automatic tick();
    exp_t h;
    @(negedge PCLK);
    chk("done_pulse", 64'(done), 64'(exp_done));
    chk("terr_pulse", 64'(timeout_err), 64'(exp_terr));
    if (exp_psel_low) chk("abort_psel_low", 64'(apb.PSEL), 64'(0));
    exp_done     = 1'b0;
    exp_terr     = 1'b0;
    exp_psel_low = 1'b0;
    last_acc     = 1'b0;
    if (PRESET) begin
      sb.delete();
      wcnt      = 0;
      prev_psel = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        sb.push_back({cmd_addr & ~32'h3, cmd_data});
        last_acc = 1'b1;
      end
      if (apb.PSEL) begin
        n_psel++;
        if (sb.size() > 0) begin
          h = sb[0];
          chk("xfer_paddr", 64'(apb.PADDR), 64'(h.a));
          chk("xfer_pwdata", 64'(apb.PWDATA), 64'(h.d));
        end else begin
          chk("sb_nonempty_on_psel", 64'(sb.size()), 64'(1));
        end
      end
      if (apb.PSEL && apb.PENABLE) begin
        n_pen++;
        if (apb.PREADY) begin
          if (sb.size() > 0) h = sb.pop_front();
          exp_done = 1'b1;
          wcnt     = 0;
        end else begin
          wcnt++;
          if (wcnt == int'(TIMEOUT)) begin
            if (sb.size() > 0) h = sb.pop_front();
            exp_terr     = 1'b1;
            exp_psel_low = 1'b1;
            wcnt         = 0;
          end
        end
      end else begin
        wcnt = 0;
      end
      if (prev_psel && !apb.PSEL) n_fall++;
      prev_psel = apb.PSEL;
      if (done) n_done++;
      if (timeout_err) n_terr++;
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    last_acc  = 1'b0;
    for (int i = 0; i < 50 && !last_acc; i++) tick();
    chk("push_accept", 64'(last_acc), 64'(1));
    cmd_valid = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
    apb.PREADY = 1'b1;
    exp_done = 1'b0; exp_terr = 1'b0; exp_psel_low = 1'b0;
    prev_psel = 1'b0; last_acc = 1'b0; wcnt = 0;
    clr();
    repeat (2) begin @(posedge PCLK); #1; end
    chk("rst_psel", 64'(apb.PSEL), 64'(0));
    chk("rst_penable", 64'(apb.PENABLE), 64'(0));
    chk("rst_pwrite", 64'(apb.PWRITE), 64'(0));
    chk("rst_paddr", 64'(apb.PADDR), 64'(0));
    chk("rst_pwdata", 64'(apb.PWDATA), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_terr", 64'(timeout_err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    PRESET = 1'b0;

    // Single write, PREADY high: exact latency
    clr();
    cmd_valid = 1'b1; cmd_addr = 32'h10; cmd_data = 32'hDEADBEEF;
    tick();
    cmd_valid = 1'b0;
    chk("s1_e0_psel", 64'(apb.PSEL), 64'(0));
    chk("s1_e0_busy", 64'(busy), 64'(1));
    tick();
    chk("s1_e1_psel", 64'(apb.PSEL), 64'(1));
    chk("s1_e1_penable", 64'(apb.PENABLE), 64'(0));
    chk("s1_e1_pwrite", 64'(apb.PWRITE), 64'(1));
    chk("s1_e1_paddr", 64'(apb.PADDR), 64'(32'h10));
    tick();
    chk("s1_e2_penable", 64'(apb.PENABLE), 64'(1));
    chk("s1_e2_pwdata", 64'(apb.PWDATA), 64'(32'hDEADBEEF));
    tick();
    chk("s1_e3_done", 64'(done), 64'(1));
    chk("s1_e3_psel", 64'(apb.PSEL), 64'(0));
    tick();
    chk("s1_done_low", 64'(done), 64'(0));
    chk("s1_busy_low", 64'(busy), 64'(0));
    chk("s1_paddr_hold", 64'(apb.PADDR), 64'(32'h10));
    chk("s1_psel_cycles", 64'(n_psel), 64'(2));
    chk("s1_pen_cycles", 64'(n_pen), 64'(1));
    chk("s1_done_count", 64'(n_done), 64'(1));

    // Three wait states
    clr();
    apb.PREADY = 1'b0;
    push(32'h20, 32'hCAFEF00D);
    for (int i = 0; i < 10 && !apb.PENABLE; i++) tick();
    chk("s2_penable_seen", 64'(apb.PENABLE), 64'(1));
    repeat (3) tick();
    apb.PREADY = 1'b1;
    repeat (3) tick();
    chk("s2_pen_cycles", 64'(n_pen), 64'(4));
    chk("s2_psel_cycles", 64'(n_psel), 64'(5));
    chk("s2_done_count", 64'(n_done), 64'(1));

    // Fill FIFO behind a stalled transfer, then release back-to-back
    clr();
    apb.PREADY = 1'b0;
    for (int i = 0; i < 5; i++) push(32'(4 * i), 32'(i + 1));
    chk("s3_full_ready", 64'(cmd_ready), 64'(0));
    chk("s3_full_busy", 64'(busy), 64'(1));
    apb.PREADY = 1'b1;
    for (int i = 0; i < 60 && n_done < 5; i++) tick();
    chk("s3_done_count", 64'(n_done), 64'(5));
    chk("s3_psel_falls", 64'(n_fall), 64'(1));
    chk("s3_psel_cycles", 64'(n_psel), 64'(12));
    chk("s3_sb_empty", 64'(sb.size()), 64'(0));

    // Timeout abort, next queued command completes
    clr();
    apb.PREADY = 1'b0;
    push(32'h40, 32'h11111111);
    push(32'h44, 32'h22222222);
    for (int i = 0; i < 60 && n_terr == 0; i++) tick();
    chk("s4_terr_seen", 64'(n_terr), 64'(1));
    chk("s4_pen_cycles", 64'(n_pen), 64'(TIMEOUT));
    apb.PREADY = 1'b1;
    for (int i = 0; i < 20 && n_done == 0; i++) tick();
    tick();
    chk("s4_done_count", 64'(n_done), 64'(1));
    chk("s4_terr_count", 64'(n_terr), 64'(1));
    chk("s4_sb_empty", 64'(sb.size()), 64'(0));

    // PREADY rising on the last allowed cycle completes
    clr();
    apb.PREADY = 1'b0;
    push(32'h50, 32'h33333333);
    for (int i = 0; i < 10 && !apb.PENABLE; i++) tick();
    repeat (TIMEOUT - 1) tick();
    apb.PREADY = 1'b1;
    repeat (3) tick();
    chk("s5_done_count", 64'(n_done), 64'(1));
    chk("s5_terr_count", 64'(n_terr), 64'(0));
    chk("s5_pen_cycles", 64'(n_pen), 64'(TIMEOUT));

    // Reset mid-ACCESS with two queued
    clr();
    apb.PREADY = 1'b0;
    push(32'h100, 32'hA0);
    push(32'h104, 32'hA1);
    push(32'h108, 32'hA2);
    for (int i = 0; i < 10 && !apb.PENABLE; i++) tick();
    chk("s6_in_access", 64'(apb.PENABLE), 64'(1));
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    chk("s6_psel", 64'(apb.PSEL), 64'(0));
    chk("s6_penable", 64'(apb.PENABLE), 64'(0));
    chk("s6_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("s6_busy", 64'(busy), 64'(0));
    chk("s6_done", 64'(done), 64'(0));
    clr();
    apb.PREADY = 1'b1;
    repeat (6) tick();
    chk("s6_no_psel", 64'(n_psel), 64'(0));
    chk("s6_no_done", 64'(n_done), 64'(0));

    // Unaligned address is forced to word alignment
    clr();
    push(32'h13, 32'h5A5A5A5A);
    for (int i = 0; i < 10 && !apb.PSEL; i++) tick();
    chk("s7_paddr_aligned", 64'(apb.PADDR), 64'(32'h10));
    for (int i = 0; i < 10 && n_done == 0; i++) tick();
    chk("s7_done_count", 64'(n_done), 64'(1));
    chk("s7_sb_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_write_master.md
# apb_write_master

APB write requester that drains a small command FIFO of (address, data) pairs from local logic and issues each as an APB write transfer (SETUP → ACCESS, wait on PREADY) toward an APB write completer. It sits between the local command source and the APB bus and provides back-to-back transfers, wait-state tolerance, a per-transfer timeout, and completion/error pulses.

## Interface
Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB write-data width
- FIFO_DEPTH, 4, command FIFO entries; power of 2, ≥ 2
- TIMEOUT, 16, max consecutive ACCESS cycles with PREADY low before abort; ≥ 1

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_addr  in  ADDR_W  write address
- cmd_data  in  DATA_W  write data
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable (ACCESS phase)
- PWRITE  out  1  APB direction; equals PSEL
- PADDR  out  ADDR_W  APB address, bits [1:0] forced to 0
- PWDATA  out  DATA_W  APB write data
- PREADY  in  1  completer ready
- done  out  1  one-cycle pulse per completed transfer
- timeout_err  out  1  one-cycle pulse per aborted transfer
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Push: cmd_valid && cmd_ready at an edge writes {cmd_addr, cmd_data} into the FIFO. cmd_ready comes from registered occupancy; when full, cmd_ready = 0 even if a pop occurs that cycle.
- Simultaneous push and pop: both occur, occupancy unchanged. Pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE: PSEL=0, PENABLE=0. If FIFO non-empty: pop head into PADDR/PWDATA, go SETUP.
  - SETUP: PSEL=1, PENABLE=0; always go ACCESS next; clear timeout counter.
  - ACCESS: PSEL=1, PENABLE=1. If PREADY=1: transfer completes, done pulses next cycle; if FIFO non-empty, pop and go SETUP directly (no IDLE cycle), else go IDLE. If PREADY=0: increment timeout counter; when counter reaches TIMEOUT, abort: go IDLE, timeout_err pulses next cycle, entry discarded.
- PADDR/PWDATA load only on pop; stable from SETUP through the end of ACCESS; hold last value in IDLE.
- Timeout counter is $clog2(TIMEOUT+1) bits and saturates; it is cleared in SETUP.

## Timing
- Reset (PRESET high at an edge): all outputs 0 except cmd_ready=1; FIFO flushed; FSM → IDLE; counters cleared. Reset mid-transfer: PSEL/PENABLE low the cycle after the reset edge, no done or timeout_err for the killed transfer.
- Latency: command accepted at edge E into an empty FIFO with FSM in IDLE → PSEL high after E+1, PENABLE high after E+2; with PREADY already high, the transfer completes at edge E+3 and done is high during the following cycle.
- Each transfer costs 2 + W cycles of PSEL, where W is the number of ACCESS cycles with PREADY low.
- Back-to-back: the ACCESS completion edge is followed directly by SETUP of the next entry; PSEL stays high and PENABLE drops for one cycle.
- Abort: PREADY low for TIMEOUT consecutive ACCESS cycles → PSEL/PENABLE low on the next cycle. A PREADY that rises in the same cycle the counter hits TIMEOUT counts as completion, not abort.
- done and timeout_err are never asserted in the same cycle.

## Test plan
- Single write, PREADY tied 1: push addr 0x10, data 0xDEADBEEF → PSEL=1 for 2 cycles, PENABLE=1 for 1 cycle, PADDR=0x10, PWDATA=0xDEADBEEF, one done pulse, busy falls after done.
- Wait states: completer holds PREADY low for 3 ACCESS cycles → PENABLE high for 4 cycles, PADDR/PWDATA stable throughout, single done.
- Back-to-back/full: push 5 commands (0x0..0x10 step 4, data 1..5) with PREADY low → cmd_ready=0 after 4 entries held in FIFO; on release, 5 transfers in order with no IDLE gap and 5 done pulses.
- Timeout: PREADY held 0, TIMEOUT=16 → after 16 ACCESS cycles PSEL drops and timeout_err pulses once; next queued command then completes normally.
- Reset mid-ACCESS with 2 queued: assert PRESET → PSEL/PENABLE=0 next cycle, cmd_ready=1, busy=0, no done; no further transfers.
- Unaligned address: push addr 0x13 → PADDR=0x10.
